// File: rtl/ni_pkg.sv
// Shared NI types: flit encoding, depacketizer states and request packet.
// Parity checking is enabled by defining NI_DEPKT_PARITY_EN.
package ni_pkg;

  localparam int NI_FLIT_W   = 16;
  localparam int NI_NUM_BODY = 4;

  typedef enum logic [1:0] {
    FT_HEAD    = 2'b00,
    FT_BODY    = 2'b01,
    FT_TAIL    = 2'b10,
    FT_INVALID = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE_ST,
    BODY_ST,
    PUSH_ST,
    DROP_ST
  } ni_depkt_state_e;

  typedef struct packed {
    logic [NI_NUM_BODY-1:0][NI_FLIT_W-1:0] body_flit;
    logic [NI_FLIT_W-1:0]                  head_flit;
  } req_packet_s;

endpackage

// File: rtl/ni_flit_parity_chk.sv
// Even-parity check over a whole flit; bit 0 carries the parity.
// Only built when NI_DEPKT_PARITY_EN is defined.
`ifdef NI_DEPKT_PARITY_EN
module ni_flit_parity_chk #(
  parameter int W = 16
) (
  input  logic [W-1:0] flit_i,
  output logic         ok_o
);

  assign ok_o = ~^flit_i;

endmodule
`endif

// File: rtl/ni_req_depacketizer.sv
// Reassembles HEAD/BODY/TAIL flits into a request packet for the req FIFO.
// Define NI_DEPKT_PARITY_EN to drop flits failing even parity.
module ni_req_depacketizer
  import ni_pkg::*;
#(
  parameter int FLIT_W   = NI_FLIT_W,
  parameter int NUM_BODY = NI_NUM_BODY
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_flit_valid,
  output logic              in_flit_ready,
  output req_packet_s       out_req_pkt,
  output logic              fifo_wreq,
  input  logic              fifo_full,
  output logic              pkt_err,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W =
    (NUM_BODY > 1) ? $clog2(NUM_BODY) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_BODY - 1);

  ni_depkt_state_e  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  req_packet_s      pkt_q, pkt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             run_q;

  logic       par_ok;
  logic       acc;
  flit_type_e ftype;

`ifdef NI_DEPKT_PARITY_EN
  ni_flit_parity_chk #(
    .W(FLIT_W)
  ) u_par (
    .flit_i(in_flit),
    .ok_o  (par_ok)
  );
`else
  assign par_ok = 1'b1;
`endif

  assign ftype = flit_type_e'(in_flit[FLIT_W-1:FLIT_W-2]);
  assign acc   = in_flit_valid & in_flit_ready;

  // run_q keeps ready low until the first edge after reset release
  assign in_flit_ready = run_q &
    ((state_q == IDLE_ST) | (state_q == BODY_ST));
  assign fifo_wreq   = (state_q == PUSH_ST) & ~fifo_full;
  assign pkt_err     = (state_q == DROP_ST);
  assign out_req_pkt = pkt_q;
  assign err_cnt     = cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_ST: begin
        if (acc) begin
          if (par_ok && ftype == FT_HEAD) begin
            pkt_d.head_flit = in_flit;
            idx_d           = '0;
            state_d         = BODY_ST;
          end else begin
            state_d = DROP_ST;
          end
        end
      end
      BODY_ST: begin
        if (acc) begin
          if (par_ok && ftype == FT_BODY
              && idx_q != LAST) begin
            pkt_d.body_flit[idx_q] = in_flit;
            idx_d = idx_q + IDX_W'(1);
          end else if (par_ok && ftype == FT_TAIL
                       && idx_q == LAST) begin
            pkt_d.body_flit[LAST] = in_flit;
            state_d = PUSH_ST;
          end else begin
            state_d = DROP_ST;
          end
        end
      end
      PUSH_ST: begin
        if (!fifo_full) state_d = IDLE_ST;
      end
      DROP_ST: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        state_d = IDLE_ST;
      end
      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE_ST;
      idx_q   <= '0;
      pkt_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ni_req_depacketizer.sv
// Bench for ni_req_depacketizer: queue-based packet model, per-cycle compare.
// Build with NI_DEPKT_PARITY_EN defined to exercise the parity variant.
module tb_ni_req_depacketizer;
  import ni_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [15:0] in_flit = '0;
  logic        in_flit_valid = 1'b0;
  logic        in_flit_ready;
  req_packet_s out_req_pkt;
  logic        fifo_wreq;
  logic        fifo_full = 1'b0;
  logic        pkt_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pulses = 0;

`ifdef NI_DEPKT_PARITY_EN
  localparam logic [15:0] B2 = 16'h4002;
  localparam int PAR_ERR = 5;
  localparam int PAR_PSH = 2;
`else
  localparam logic [15:0] B2 = 16'h4003;
  localparam int PAR_ERR = 2;
  localparam int PAR_PSH = 3;
`endif

  always #5 PCLK = ~PCLK;

  ni_req_depacketizer dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .in_flit      (in_flit),
    .in_flit_valid(in_flit_valid),
    .in_flit_ready(in_flit_ready),
    .out_req_pkt  (out_req_pkt),
    .fifo_wreq    (fifo_wreq),
    .fifo_full    (fifo_full),
    .pkt_err      (pkt_err),
    .err_cnt      (err_cnt)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] fp(input logic [15:0] f);
`ifdef NI_DEPKT_PARITY_EN
    return {f[15:1], ^f[15:1]};
`else
    return f;
`endif
  endfunction

  function automatic bit par_ok(input logic [15:0] f);
`ifdef NI_DEPKT_PARITY_EN
    return (^f) == 1'b0;
`else
    return f[0] | 1'b1;
`endif
  endfunction

  // model: flits of the packet being collected, plus pending push/drop
  logic [15:0] coll[$];
  bit          m_started = 0;
  bit          m_push = 0;
  bit          m_drop = 0;
  int          m_cnt = 0;
  logic [15:0] m_head = '0;
  logic [15:0] m_body[4] = '{default: '0};

  always @(negedge PRESETn) begin
    coll.delete();
    m_started = 0;
    m_push = 0;
    m_drop = 0;
    m_cnt = 0;
    m_head = '0;
    for (int i = 0; i < 4; i++) m_body[i] = '0;
  end

  always @(posedge PCLK) begin
    bit rdy;
    int n;
    logic [1:0] t;
    if (PRESETn) begin
      rdy = m_started && !m_push && !m_drop;
      m_started = 1;
      t = in_flit[15:14];
      if (m_drop) begin
        if (m_cnt < 255) m_cnt++;
        m_drop = 0;
      end else if (m_push) begin
        if (!fifo_full) m_push = 0;
      end else if (in_flit_valid && rdy) begin
        if (coll.size() == 0) begin
          if (t == 2'b00 && par_ok(in_flit)) begin
            m_head = in_flit;
            coll.push_back(in_flit);
          end else begin
            m_drop = 1;
          end
        end else begin
          n = coll.size() - 1;
          if (par_ok(in_flit) && t == 2'b01 && n < 3) begin
            m_body[n] = in_flit;
            coll.push_back(in_flit);
          end else if (par_ok(in_flit) && t == 2'b10
                       && n == 3) begin
            m_body[n] = in_flit;
            m_push = 1;
            coll.delete();
          end else begin
            m_drop = 1;
            coll.delete();
          end
        end
      end
    end
  end

  always @(negedge PCLK) begin
    chk("ready", 64'(in_flit_ready),
        64'(m_started && !m_push && !m_drop));
    chk("wreq", 64'(fifo_wreq), 64'(m_push && !fifo_full));
    chk("pkt_err", 64'(pkt_err), 64'(m_drop));
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    chk("head", 64'(out_req_pkt.head_flit), 64'(m_head));
    for (int i = 0; i < 4; i++)
      chk("body", 64'(out_req_pkt.body_flit[i]), 64'(m_body[i]));
    if (fifo_wreq === 1'b1) pushes++;
    if (pkt_err === 1'b1) pulses++;
  end

  task automatic send(input logic [15:0] f);
    int n;
    n = 0;
    in_flit = f;
    in_flit_valid = 1'b1;
    @(negedge PCLK);
    while (in_flit_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
    @(posedge PCLK);
    #1;
    in_flit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge PCLK);
    chk("rst_ready", 64'(in_flit_ready), 64'(0));
    chk("rst_cnt", 64'(err_cnt), 64'(0));
    chk("rst_pkt", 64'(out_req_pkt[63:0]), 64'(0));
    PRESETn = 1'b1;
    #1;
    chk("ready_pre_edge", 64'(in_flit_ready), 64'(0));
    @(posedge PCLK);
    #1;
    chk("ready_first_edge", 64'(in_flit_ready), 64'(1));

    // good packet
    send(fp(16'h0000));
    send(fp(16'h4001));
    send(fp(16'h4002));
    send(fp(16'h4003));
    send(fp(16'h8004));
    chk("wreq_latency", 64'(fifo_wreq), 64'(1));
    idle(2);
    chk("good_push", 64'(pushes), 64'(1));
    chk("good_b0", 64'(out_req_pkt.body_flit[0]), 64'(16'h4001));
    chk("good_b1", 64'(out_req_pkt.body_flit[1]), 64'(16'h4002));
    chk("good_b2", 64'(out_req_pkt.body_flit[2]), 64'(B2));
    chk("good_b3", 64'(out_req_pkt.body_flit[3]), 64'(16'h8004));
    chk("good_err", 64'(err_cnt), 64'(0));

    // backpressure from the tail cycle
    send(fp(16'h0100));
    send(fp(16'h4101));
    send(fp(16'h4102));
    send(fp(16'h4103));
    fifo_full = 1'b1;
    send(fp(16'h8104));
    repeat (5) begin
      chk("bp_ready", 64'(in_flit_ready), 64'(0));
      chk("bp_wreq", 64'(fifo_wreq), 64'(0));
      @(posedge PCLK);
      #1;
    end
    fifo_full = 1'b0;
    #1;
    chk("bp_release", 64'(fifo_wreq), 64'(1));
    chk("bp_b3", 64'(out_req_pkt.body_flit[3]), 64'(fp(16'h8104)));
    idle(2);
    chk("bp_push", 64'(pushes), 64'(2));

    // framing errors
    send(fp(16'h4001));
    send(fp(16'h0000));
    send(fp(16'h8004));
    idle(3);
    chk("frm_err", 64'(err_cnt), 64'(2));
    chk("frm_pulses", 64'(pulses), 64'(2));
    chk("frm_push", 64'(pushes), 64'(2));

    // one body flit with bit 0 flipped
    send(fp(16'h0000));
    send(fp(16'h4001));
    send(fp(16'h4002) ^ 16'h0001);
    send(fp(16'h4003));
    send(fp(16'h8004));
    idle(4);
    chk("par_err", 64'(err_cnt), 64'(PAR_ERR));
    chk("par_push", 64'(pushes), 64'(PAR_PSH));

    // reset mid-packet
    send(fp(16'h0000));
    send(fp(16'h4055));
    send(fp(16'h4066));
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_ready", 64'(in_flit_ready), 64'(0));
    chk("arst_wreq", 64'(fifo_wreq), 64'(0));
    chk("arst_err", 64'(pkt_err), 64'(0));
    chk("arst_cnt", 64'(err_cnt), 64'(0));
    chk("arst_pkt", 64'(out_req_pkt[63:0]), 64'(0));
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle(2);
    chk("post_rst_push", 64'(pushes), 64'(PAR_PSH));
    send(fp(16'h0011));
    send(fp(16'h4010));
    send(fp(16'h4020));
    send(fp(16'h4030));
    send(fp(16'h8004));
    idle(2);
    chk("rst_pkt_push", 64'(pushes), 64'(PAR_PSH + 1));
    chk("rst_pkt_head", 64'(out_req_pkt.head_flit), 64'(16'h0011));
    chk("rst_pkt_b0", 64'(out_req_pkt.body_flit[0]), 64'(16'h4010));
    chk("rst_pkt_err", 64'(err_cnt), 64'(0));

    // saturation
    repeat (260) send(fp(16'h4001));
    idle(3);
    chk("sat_cnt", 64'(err_cnt), 64'(255));
    send(fp(16'h4001));
    idle(3);
    chk("sat_hold", 64'(err_cnt), 64'(255));
    chk("sat_push", 64'(pushes), 64'(PAR_PSH + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
